// File: rtl/ptcalc_mul_pkg.sv
// Shared types and helpers for the pT-calc signed x unsigned multiplier family.
// Latency: none (declarations only).
// Backpressure: not applicable.
package ptcalc_mul_pkg;

  // Default operand widths of the original 8s x 15u multiplier.
  localparam int A_W_DFLT = 8;
  localparam int B_W_DFLT = 15;

  // Exact product width for the default operands: the unsigned operand gains a
  // zero sign bit, so A_W + (B_W + 1) bits hold every product.
  localparam int FULL_W = A_W_DFLT + B_W_DFLT + 1;

  // Working width of the saturation helper. Values are sign-extended into it,
  // so any datapath up to this width can share the function.
  localparam int SAT_MAX_W = 64;

  typedef struct packed {
    logic                        ovf;
    logic signed [SAT_MAX_W-1:0] val;
  } sat_t;

  // Clamp a signed value to the signed range of 'width' bits.
  // ovf is set whenever clamping was needed.
  function automatic sat_t sat_signed(input logic signed [SAT_MAX_W-1:0] value,
                                      input int                          width);
    sat_t                        res;
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = ~hi;
    res.ovf = 1'b0;
    res.val = value;
    if (value > hi) begin
      res.ovf = 1'b1;
      res.val = hi;
    end else if (value < lo) begin
      res.ovf = 1'b1;
      res.val = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/ptcalc_mul_round_sat.sv
// Round (half up) or truncate, arithmetic right shift, then saturate or wrap a full product.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller decides when the result is registered.
module ptcalc_mul_round_sat
  import ptcalc_mul_pkg::*;
#(
  parameter int FULL_W   = A_W_DFLT + B_W_DFLT + 1,
  parameter int P_W      = 22,
  parameter int SHIFT    = 0,
  parameter int ROUND_EN = 1,
  parameter int SAT_EN   = 1
) (
  input  logic signed [FULL_W-1:0] prod,
  output logic signed [P_W-1:0]    dout,
  output logic                     ovf
);

  // One extra bit so adding the rounding constant can never overflow.
  localparam int R_W = FULL_W + 1;

  logic signed [R_W-1:0]       rnd;
  logic signed [R_W-1:0]       shf;
  logic signed [SAT_MAX_W-1:0] shf_ext;
  sat_t                        sat_res;

  generate
    if (ROUND_EN != 0 && SHIFT > 0) begin : g_round
      // Half an output LSB, so the floor shift below becomes round-half-up.
      localparam logic signed [R_W-1:0] HALF = R_W'(1) << (SHIFT - 1);
      assign rnd = R_W'(prod) + HALF;
    end else begin : g_trunc
      assign rnd = R_W'(prod);
    end
  endgenerate

  assign shf     = rnd >>> SHIFT;
  assign shf_ext = SAT_MAX_W'(shf);

  // Range check is always evaluated: ovf flags out-of-range beats in both modes,
  // only the data path differs between clamping and keeping the low bits.
  always_comb begin
    sat_res = sat_signed(shf_ext, P_W);
    ovf     = sat_res.ovf;
    dout    = P_W'((SAT_EN != 0) ? sat_res.val : shf_ext);
  end

endmodule

// File: rtl/ptcalc_mul_sxu_pipe.sv
// Pipelined signed x unsigned multiply with round/shift/saturate for the pT-calc datapath.
// Latency: NUM_STAGE cycles from accept to out_valid when the pipe keeps advancing.
// Backpressure: whole pipe advances only when ce=1 and the output slot is free or draining.
module ptcalc_mul_sxu_pipe
  import ptcalc_mul_pkg::*;
#(
  parameter int A_W       = A_W_DFLT,
  parameter int B_W       = B_W_DFLT,
  parameter int P_W       = 22,
  parameter int NUM_STAGE = 3,
  parameter int SHIFT     = 0,
  parameter int ROUND_EN  = 1,
  parameter int SAT_EN    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [A_W-1:0] din0,
  input  logic        [B_W-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [P_W-1:0] dout,
  output logic                  ovf
);

  localparam int PROD_W = A_W + B_W + 1;

  logic                     adv;
  logic signed [PROD_W-1:0] mult;
  logic signed [PROD_W-1:0] rs_prod;
  logic                     rs_vld;
  logic signed [P_W-1:0]    rs_dout;
  logic                     rs_ovf;

  // A single advance enable for every stage: the pipe moves as one shift register,
  // so a stalled output freezes everything behind it and nothing is lost.
  assign adv      = ce & (~out_valid | out_ready);
  assign in_ready = adv;

  // din1 is unsigned: zero-extend before the signed multiply so it never reads as negative.
  assign mult = PROD_W'(din0) * $signed(PROD_W'(din1));

  generate
    if (NUM_STAGE == 1) begin : g_single
      // Single register: multiply and round/sat both feed the output register directly.
      // in_valid alone suffices because the register only loads when in_ready is high.
      assign rs_prod = mult;
      assign rs_vld  = in_valid;
    end else begin : g_chain
      localparam int DEPTH = NUM_STAGE - 1;

      logic [DEPTH-1:0]         vld;
      logic signed [PROD_W-1:0] prod [DEPTH];

      // Product pipeline: stage 0 is the multiplier register, later stages carry it unchanged.
      always_ff @(posedge clk) begin
        if (reset) begin
          vld <= '0;
          for (int i = 0; i < DEPTH; i++) prod[i] <= '0;
        end else if (adv) begin
          vld[0]  <= in_valid;
          prod[0] <= mult;
          for (int i = 1; i < DEPTH; i++) begin
            vld[i]  <= vld[i-1];
            prod[i] <= prod[i-1];
          end
        end
      end

      assign rs_prod = prod[DEPTH-1];
      assign rs_vld  = vld[DEPTH-1];
    end
  endgenerate

  ptcalc_mul_round_sat #(
    .FULL_W   (PROD_W),
    .P_W      (P_W),
    .SHIFT    (SHIFT),
    .ROUND_EN (ROUND_EN),
    .SAT_EN   (SAT_EN)
  ) u_round_sat (
    .prod (rs_prod),
    .dout (rs_dout),
    .ovf  (rs_ovf)
  );

  // Final stage: registers the rounded/saturated result; holds while stalled or ce is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      dout      <= '0;
      ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= rs_vld;
      dout      <= rs_dout;
      ovf       <= rs_ovf;
    end
  end

endmodule

// File: tb/tb_ptcalc_mul_sxu_pipe.sv
// Scoreboard bench: four configurations of the multiplier share one input stream.
// Instance 0 is the default build and sees the directed backpressure; others drain freely.
// Expected results come from a plain-integer reference of the round/shift/saturate rules.
module tb_ptcalc_mul_sxu_pipe;

  localparam int NI = 4;

  typedef struct packed {
    logic [21:0] d;
    logic        o;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              ce;
  logic              in_valid;
  logic              out_ready;
  logic signed [7:0] din0;
  logic [14:0]       din1;

  logic               irdy [NI];
  logic               ov   [NI];
  logic signed [21:0] dv   [NI];
  logic               ofl  [NI];

  exp_t sbq [NI][$];
  int   checks   = 0;
  int   failures = 0;
  bit   rnd_on   = 1'b0;

  always #5 clk = ~clk;

  // 0: default (no shift, round, saturate, 3 stages)
  ptcalc_mul_sxu_pipe #(.NUM_STAGE(3), .SHIFT(0), .ROUND_EN(1), .SAT_EN(1)) dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(irdy[0]),
    .din0(din0), .din1(din1), .out_valid(ov[0]), .out_ready(out_ready),
    .dout(dv[0]), .ovf(ofl[0]));
  // 1: wrap mode, single stage
  ptcalc_mul_sxu_pipe #(.NUM_STAGE(1), .SHIFT(0), .ROUND_EN(1), .SAT_EN(0)) dut_wrap (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(irdy[1]),
    .din0(din0), .din1(din1), .out_valid(ov[1]), .out_ready(1'b1),
    .dout(dv[1]), .ovf(ofl[1]));
  // 2: shift 4 with rounding, saturate, 2 stages
  ptcalc_mul_sxu_pipe #(.NUM_STAGE(2), .SHIFT(4), .ROUND_EN(1), .SAT_EN(1)) dut_rnd (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(irdy[2]),
    .din0(din0), .din1(din1), .out_valid(ov[2]), .out_ready(1'b1),
    .dout(dv[2]), .ovf(ofl[2]));
  // 3: shift 4 truncating, wrap, 4 stages
  ptcalc_mul_sxu_pipe #(.NUM_STAGE(4), .SHIFT(4), .ROUND_EN(0), .SAT_EN(0)) dut_trn (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(irdy[3]),
    .din0(din0), .din1(din1), .out_valid(ov[3]), .out_ready(1'b1),
    .dout(dv[3]), .ovf(ofl[3]));

  // Reference: exact integer product, optional +half, floor divide by 2^shift,
  // then clamp or keep the low 22 bits.
  function automatic exp_t model(input int inst, input logic signed [7:0] a, input logic [14:0] b);
    longint p, s, mx, mn;
    int     sh;
    bit     rnd, sat;
    exp_t   e;
    case (inst)
      0:       begin sh = 0; rnd = 1; sat = 1; end
      1:       begin sh = 0; rnd = 1; sat = 0; end
      2:       begin sh = 4; rnd = 1; sat = 1; end
      default: begin sh = 4; rnd = 0; sat = 0; end
    endcase
    p = longint'(a) * longint'(b);
    if (rnd && sh > 0) p = p + (longint'(1) << (sh - 1));
    s  = p >>> sh;
    mx = (longint'(1) << 21) - 1;
    mn = -(longint'(1) << 21);
    e.o = (s > mx) || (s < mn);
    if (sat && s > mx) s = mx;
    else if (sat && s < mn) s = mn;
    e.d = s[21:0];
    return e;
  endfunction

  function automatic logic signed [7:0] pick_a();
    case ($urandom_range(0, 5))
      0:       return 8'h80;
      1:       return 8'h7f;
      2:       return 8'h00;
      3:       return 8'hff;
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic logic [14:0] pick_b();
    case ($urandom_range(0, 5))
      0:       return 15'h7fff;
      1:       return 15'h0000;
      2:       return 15'h0001;
      3:       return 15'h0008;
      default: return 15'($urandom);
    endcase
  endfunction

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NI; i++) n += sbq[i].size();
    return n;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Accept monitor: an accepted beat's expected result is queued per instance.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < NI; i++) sbq[i].delete();
    end else begin
      for (int i = 0; i < NI; i++)
        if (in_valid && irdy[i]) sbq[i].push_back(model(i, din0, din1));
    end
  end

  // Output monitor: a beat is consumed only on out_valid & out_ready & ce.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && ce) begin
      for (int i = 0; i < NI; i++) begin
        if (ov[i] && (i != 0 || out_ready)) begin
          checks++;
          if (sbq[i].size() == 0) begin
            failures++;
            $display("FAIL out%0d unexpected beat dout=%0d ovf=%0b", i, dv[i], ofl[i]);
          end else begin
            e = sbq[i].pop_front();
            if (dv[i] !== e.d || ofl[i] !== e.o) begin
              failures++;
              $display("FAIL out%0d dout=%0d ovf=%0b expected dout=%0d ovf=%0b",
                       i, dv[i], ofl[i], $signed(e.d), e.o);
            end
          end
        end
      end
    end
  end

  // Random ce/out_ready pattern for the soak phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_on) begin
        out_ready = ($urandom_range(0, 3) != 0);
        ce        = ($urandom_range(0, 7) != 0);
      end
    end
  end

  // Offer one beat and hold it until instance 0 accepts it.
  task automatic send(input logic signed [7:0] a, input logic [14:0] b);
    int t = 0;
    bit acc;
    din0 = a;
    din1 = b;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = irdy[0] && !reset;
      @(posedge clk);
      #1;
      t++;
    end while (!acc && t < 200);
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout in_ready stuck low for %0d cycles", t);
    end
    in_valid = 1'b0;
  endtask

  // From an idle pipe: one beat, count edges until instance 0 shows it.
  task automatic lat_check(input logic signed [7:0] a, input logic [14:0] b, input string nm);
    int lat;
    din0 = a;
    din1 = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!ov[0] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk(nm, lat, 3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $finish;
  end

  initial begin
    logic signed [7:0]  ta [10];
    logic        [14:0] tb [10];
    logic signed [21:0] held_d;
    logic               held_v;
    int                 t;

    ta = '{8'h80, 8'h7f, 8'h01, 8'hff, 8'h01, 8'hff, 8'h00, 8'hff, 8'h80, 8'h7f};
    tb = '{15'h7fff, 15'h7fff, 15'd8, 15'd8, 15'd7, 15'd7, 15'd12345, 15'h7fff, 15'd0, 15'd1};

    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1; din0 = '0; din1 = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_vld%0d", i), longint'(ov[i]), 0);
      chk($sformatf("rst_dout%0d", i), longint'(dv[i]), 0);
      chk($sformatf("rst_ovf%0d", i), longint'(ofl[i]), 0);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic product and first-beat latency.
    lat_check(8'sd3, 15'd5, "latency_first");
    repeat (6) @(posedge clk);
    #1;

    // Corner products: extremes, rounding ties, zero.
    for (int k = 0; k < 10; k++) send(ta[k], tb[k]);
    repeat (8) @(posedge clk);
    #1;

    // Back-to-back stream with a 5-cycle downstream stall in the middle.
    fork
      for (int k = 0; k < 10; k++) send(8'(k * 13 - 60), 15'(k * 2000 + 3));
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        held_d = dv[0];
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("stall_in_ready", longint'(irdy[0]), 0);
          chk("stall_out_valid", longint'(ov[0]), 1);
          chk("stall_dout_hold", longint'(dv[0]), longint'(held_d));
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;

    // Freeze with beats in flight.
    send(8'sd100, 15'd20000);
    send(-8'sd77, 15'd12000);
    send(8'sd5, 15'd31000);
    ce = 1'b0;
    held_d = dv[0];
    held_v = ov[0];
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("ce_in_ready", longint'(irdy[0]), 0);
      chk("ce_out_valid_hold", longint'(ov[0]), longint'(held_v));
      chk("ce_dout_hold", longint'(dv[0]), longint'(held_d));
      @(posedge clk);
      #1;
    end
    ce = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    // Reset with beats in flight; pipe must come back empty.
    send(8'sd11, 15'd300);
    send(-8'sd9, 15'd400);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst2_out_valid", longint'(ov[0]), 0);
    chk("rst2_dout", longint'(dv[0]), 0);
    chk("rst2_ovf", longint'(ofl[0]), 0);
    lat_check(-8'sd7, 15'd1234, "latency_after_reset");
    repeat (6) @(posedge clk);
    #1;

    // Random soak with random ce and downstream readiness.
    rnd_on = 1'b1;
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(pick_a(), pick_b());
    end
    rnd_on = 1'b0;
    @(posedge clk);
    #2;
    ce = 1'b1;
    out_ready = 1'b1;

    t = 0;
    while (pending() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    #2;
    for (int i = 0; i < NI; i++)
      chk($sformatf("drain_empty%0d", i), longint'(sbq[i].size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
